// File: rtl/fb_scanout_if.sv
// Bundle between the video timing generator / framebuffer read port and the
// scan-out block; the master side drives timing and RAM data, the slave side is fb_scanout.
interface fb_scanout_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 14
);
  logic                  de_i;
  logic                  hsync_i;
  logic                  vsync_i;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] pixel_o;
  logic                  de_o;
  logic                  hsync_o;
  logic                  vsync_o;

  modport master (
    output de_i, hsync_i, vsync_i, rd_data,
    input  rd_addr, pixel_o, de_o, hsync_o, vsync_o
  );

  modport slave (
    input  de_i, hsync_i, vsync_i, rd_data,
    output rd_addr, pixel_o, de_o, hsync_o, vsync_o
  );
endinterface

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: maps the raster position onto an integer-upscaled image
// window, reads the framebuffer and re-aligns the timing signals to the 1-cycle RAM read.
module fb_scanout #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 14,
  parameter int                    FB_W       = 160,
  parameter int                    FB_H       = 120,
  parameter int                    SCALE_LOG2 = 2,
  parameter logic [DATA_WIDTH-1:0] BG_COLOR   = {DATA_WIDTH{1'b0}}
) (
  input logic         clk,
  input logic         rst,
  fb_scanout_if.slave bus
);
  localparam int XW = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam int CW = $clog2(FB_W + 1);
  localparam int RW = $clog2(FB_H + 1);
  localparam logic [XW-1:0]         X_MAX    = XW'((32'd1 << SCALE_LOG2) - 32'd1);
  localparam logic [XW-1:0]         X_ONE    = XW'(1'b1);
  localparam logic [CW-1:0]         COL_END  = CW'(FB_W);
  localparam logic [CW-1:0]         COL_ONE  = CW'(1'b1);
  localparam logic [RW-1:0]         ROW_END  = RW'(FB_H);
  localparam logic [RW-1:0]         ROW_ONE  = RW'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] LINE_INC = ADDR_WIDTH'(FB_W);

  logic [XW-1:0]         xrep_r, xrep_s;
  logic [XW-1:0]         yrep_r, yrep_s;
  logic [CW-1:0]         col_r, col_s;
  logic [RW-1:0]         row_r, row_s;
  logic [ADDR_WIDTH-1:0] line_base_r, line_base_s;
  logic                  synced_r, synced_s;
  logic                  in_win_r, de_q_r, hs_q_r, vs_q_r;
  logic [DATA_WIDTH-1:0] pixel_r;
  logic                  de_o_r, hs_o_r, vs_o_r;
  logic                  frame_start_s, line_end_s, in_win_s;
  logic [ADDR_WIDTH-1:0] col_addr_s;

  assign frame_start_s = bus.vsync_i && !vs_q_r;
  assign line_end_s    = de_q_r && !bus.de_i;
  assign in_win_s      = synced_r && bus.de_i && (col_r < COL_END) && (row_r < ROW_END);
  // Past the right edge col sits at FB_W; fold it back so the read stays inside the image.
  assign col_addr_s    = (col_r < COL_END) ? ADDR_WIDTH'(col_r) : {ADDR_WIDTH{1'b0}};

  assign bus.rd_addr = line_base_r + col_addr_s;
  assign bus.pixel_o = pixel_r;
  assign bus.de_o    = de_o_r;
  assign bus.hsync_o = hs_o_r;
  assign bus.vsync_o = vs_o_r;

  // Raster-position counters; frame start outranks line end and pixel advance.
  always_comb begin
    xrep_s      = xrep_r;
    yrep_s      = yrep_r;
    col_s       = col_r;
    row_s       = row_r;
    line_base_s = line_base_r;
    synced_s    = synced_r;
    if (frame_start_s) begin
      xrep_s      = {XW{1'b0}};
      yrep_s      = {XW{1'b0}};
      col_s       = {CW{1'b0}};
      row_s       = {RW{1'b0}};
      line_base_s = {ADDR_WIDTH{1'b0}};
      synced_s    = 1'b1;
    end else if (line_end_s) begin
      xrep_s = {XW{1'b0}};
      col_s  = {CW{1'b0}};
      yrep_s = (yrep_r == X_MAX) ? {XW{1'b0}} : (yrep_r + X_ONE);
      if ((yrep_r == X_MAX) && (row_r < ROW_END)) begin
        row_s       = row_r + ROW_ONE;
        line_base_s = line_base_r + LINE_INC;
      end else begin
        row_s       = row_r;
        line_base_s = line_base_r;
      end
    end else if (bus.de_i) begin
      xrep_s = (xrep_r == X_MAX) ? {XW{1'b0}} : (xrep_r + X_ONE);
      if ((xrep_r == X_MAX) && (col_r < COL_END)) begin
        col_s = col_r + COL_ONE;
      end else begin
        col_s = col_r;
      end
    end else begin
      synced_s = synced_r;
    end
  end

  // Counter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      xrep_r      <= {XW{1'b0}};
      yrep_r      <= {XW{1'b0}};
      col_r       <= {CW{1'b0}};
      row_r       <= {RW{1'b0}};
      line_base_r <= {ADDR_WIDTH{1'b0}};
      synced_r    <= 1'b0;
    end else begin
      xrep_r      <= xrep_s;
      yrep_r      <= yrep_s;
      col_r       <= col_s;
      row_r       <= row_s;
      line_base_r <= line_base_s;
      synced_r    <= synced_s;
    end
  end

  // Two-stage output pipeline: stage 1 waits out the RAM read, stage 2 selects the pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_win_r <= 1'b0;
      de_q_r   <= 1'b0;
      hs_q_r   <= 1'b0;
      vs_q_r   <= 1'b0;
      pixel_r  <= {DATA_WIDTH{1'b0}};
      de_o_r   <= 1'b0;
      hs_o_r   <= 1'b0;
      vs_o_r   <= 1'b0;
    end else begin
      in_win_r <= in_win_s;
      de_q_r   <= bus.de_i;
      hs_q_r   <= bus.hsync_i;
      vs_q_r   <= bus.vsync_i;
      pixel_r  <= in_win_r ? bus.rd_data : BG_COLOR;
      de_o_r   <= de_q_r;
      hs_o_r   <= hs_q_r;
      vs_o_r   <= vs_q_r;
    end
  end
endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout: a 4x2 image upscaled 2x, a behavioural raster
// model (line/pixel indices since frame start) predicts every output two cycles ahead.
module tb_fb_scanout;
  localparam int         DW = 8;
  localparam int         AW = 4;
  localparam int         FW = 4;
  localparam int         FH = 2;
  localparam int         S  = 2;
  localparam logic [7:0] BG = 8'h3C;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] ram [0:15];

  fb_scanout_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fb_scanout #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FB_W(FW), .FB_H(FH),
    .SCALE_LOG2(1), .BG_COLOR(BG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Framebuffer port b: registered read.
  always @(posedge clk) bus.rd_data <= ram[bus.rd_addr];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: line index and pixel index since the last frame start.
  int         m_line, m_pix;
  bit         m_synced, m_pde, m_pvs;
  logic [7:0] p_pix, o_pix;
  logic       p_de, p_hs, p_vs, o_de, o_hs, o_vs;

  function automatic logic [AW-1:0] model_addr();
    int c;
    c = m_pix / S;
    if (c >= FW) c = 0;
    return AW'((m_line / S) * FW + c);
  endfunction

  function automatic bit addr_known();
    return (m_line / S) < FH;
  endfunction

  task automatic tick(input logic r);
    rst = r;
    @(posedge clk);
    if (r) begin
      {o_pix, o_de, o_hs, o_vs} = {8'h00, 1'b0, 1'b0, 1'b0};
      {p_pix, p_de, p_hs, p_vs} = {BG, 1'b0, 1'b0, 1'b0};
      m_synced = 1'b0; m_line = 0; m_pix = 0; m_pde = 1'b0; m_pvs = 1'b0;
    end else begin
      {o_pix, o_de, o_hs, o_vs} = {p_pix, p_de, p_hs, p_vs};
      p_de = bus.de_i; p_hs = bus.hsync_i; p_vs = bus.vsync_i;
      if (bus.de_i && m_synced && m_line < FH * S && m_pix < FW * S)
        p_pix = ram[(m_line / S) * FW + m_pix / S];
      else
        p_pix = BG;
      if (bus.vsync_i && !m_pvs) begin
        m_line = 0; m_pix = 0; m_synced = 1'b1;
      end else if (m_pde && !bus.de_i) begin
        m_pix = 0; m_line++;
      end else if (bus.de_i) begin
        m_pix++;
      end
      m_pde = bus.de_i; m_pvs = bus.vsync_i;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic vs);
    for (int i = 0; i < n; i++) begin
      bus.de_i = 1'b0; bus.hsync_i = 1'b0; bus.vsync_i = vs;
      tick(1'b0);
    end
  endtask

  task automatic vsync_pulse();
    idle(2, 1'b0); idle(2, 1'b1); idle(2, 1'b0);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      bus.de_i = 1'($urandom); bus.hsync_i = 1'($urandom); bus.vsync_i = 1'($urandom);
      tick(1'b1);
      n_checks++;
      if (bus.rd_addr !== 4'h0 || bus.pixel_o !== 8'h00 || bus.de_o !== 1'b0 ||
          bus.hsync_o !== 1'b0 || bus.vsync_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset c=%0d got addr=%h pix=%h de=%b hs=%b vs=%b, want all zero",
                 c, bus.rd_addr, bus.pixel_o, bus.de_o, bus.hsync_o, bus.vsync_o);
      end
    end
  endtask

  task automatic test_line_addr();
    logic [AW-1:0] tab [10] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd0, 4'd0};
    vsync_pulse();
    for (int k = 0; k < 16; k++) begin
      bus.de_i = (k < 10); bus.hsync_i = (k == 12); bus.vsync_i = 1'b0;
      if (k < 10) begin
        n_checks++;
        if (bus.rd_addr !== tab[k]) begin
          n_fail++;
          $display("FAIL line_addr k=%0d got %0d want %0d", k, bus.rd_addr, tab[k]);
        end
      end
      tick(1'b0);
      n_checks++;
      if (bus.pixel_o !== o_pix || bus.de_o !== o_de || bus.hsync_o !== o_hs || bus.vsync_o !== o_vs) begin
        n_fail++;
        $display("FAIL line_out k=%0d got pix=%h de=%b hs=%b vs=%b want pix=%h de=%b hs=%b vs=%b",
                 k, bus.pixel_o, bus.de_o, bus.hsync_o, bus.vsync_o, o_pix, o_de, o_hs, o_vs);
      end
    end
  endtask

  task automatic test_frame();
    logic [AW-1:0] base [4] = '{4'd0, 4'd0, 4'd4, 4'd4};
    vsync_pulse();
    for (int ln = 0; ln < 5; ln++) begin
      for (int k = 0; k < 16; k++) begin
        bus.de_i = (k < 10); bus.hsync_i = (k == 12 || k == 13); bus.vsync_i = 1'b0;
        if (k == 0 && ln < 4) begin
          n_checks++;
          if (bus.rd_addr !== base[ln]) begin
            n_fail++;
            $display("FAIL frame_base line=%0d got %0d want %0d", ln, bus.rd_addr, base[ln]);
          end
        end else if (k < 10 && addr_known()) begin
          n_checks++;
          if (bus.rd_addr !== model_addr()) begin
            n_fail++;
            $display("FAIL frame_addr line=%0d k=%0d got %0d want %0d", ln, k, bus.rd_addr, model_addr());
          end
        end
        tick(1'b0);
        n_checks++;
        if (bus.pixel_o !== o_pix || bus.de_o !== o_de || bus.hsync_o !== o_hs ||
            (ln == 4 && k >= 2 && bus.pixel_o !== BG)) begin
          n_fail++;
          $display("FAIL frame_out line=%0d k=%0d got pix=%h de=%b hs=%b want pix=%h de=%b hs=%b",
                   ln, k, bus.pixel_o, bus.de_o, bus.hsync_o, o_pix, o_de, o_hs);
        end
      end
    end
  endtask

  task automatic test_latency();
    ram[0] = 8'hA5;
    vsync_pulse();
    idle(3, 1'b0);
    bus.de_i = 1'b1;
    tick(1'b0);
    n_checks++;
    if (bus.de_o !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_t1 got de_o=%b want 0", bus.de_o);
    end
    tick(1'b0);
    n_checks++;
    if (bus.de_o !== 1'b1 || bus.pixel_o !== 8'hA5) begin
      n_fail++;
      $display("FAIL latency_t2 got de_o=%b pix=%h want de_o=1 pix=a5", bus.de_o, bus.pixel_o);
    end
    tick(1'b0); tick(1'b0);
    idle(6, 1'b0);
  endtask

  task automatic test_random();
    logic h_prev, v_prev;
    idle(1, 1'b0);
    h_prev = 1'b0; v_prev = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bus.de_i    = ($urandom_range(0, 9) < 7);
      bus.hsync_i = 1'($urandom);
      bus.vsync_i = ($urandom_range(0, 40) == 0);
      if (addr_known()) begin
        n_checks++;
        if (bus.rd_addr !== model_addr()) begin
          n_fail++;
          $display("FAIL rand_addr c=%0d got %0d want %0d", c, bus.rd_addr, model_addr());
        end
      end
      tick(1'b0);
      n_checks++;
      if (bus.pixel_o !== o_pix || bus.de_o !== o_de || bus.hsync_o !== h_prev || bus.vsync_o !== v_prev) begin
        n_fail++;
        $display("FAIL rand_out c=%0d got pix=%h de=%b hs=%b vs=%b want pix=%h de=%b hs=%b vs=%b",
                 c, bus.pixel_o, bus.de_o, bus.hsync_o, bus.vsync_o, o_pix, o_de, h_prev, v_prev);
      end
      h_prev = bus.hsync_i; v_prev = bus.vsync_i;
    end
    idle(40, 1'b0);
  endtask

  task automatic test_reset_midframe();
    int k;
    vsync_pulse();
    for (int i = 0; i < 16; i++) begin
      bus.de_i = (i < 10); bus.hsync_i = 1'b0; bus.vsync_i = 1'b0;
      tick(1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      bus.de_i = 1'b1;
      tick(1'b0);
    end
    tick(1'b1); tick(1'b1);
    for (int i = 0; i < 43; i++) begin
      bus.de_i = ((i % 16) < 5) ? (i < 5) || ((i - 11) % 16 < 10 && i >= 11) : ((i - 11) % 16 < 10 && i >= 11);
      bus.hsync_i = 1'($urandom); bus.vsync_i = 1'b0;
      tick(1'b0);
      n_checks++;
      if (bus.pixel_o !== BG || bus.pixel_o !== o_pix || bus.de_o !== o_de) begin
        n_fail++;
        $display("FAIL unsynced i=%0d got pix=%h de=%b want pix=%h de=%b", i, bus.pixel_o, bus.de_o, BG, o_de);
      end
    end
    vsync_pulse();
    k = 0;
    for (int i = 0; i < 16; i++) begin
      bus.de_i = (i < 10); bus.hsync_i = 1'b0; bus.vsync_i = 1'b0;
      tick(1'b0);
      if (bus.de_o === 1'b1) begin
        n_checks++;
        if (bus.pixel_o !== ((k < 8) ? ram[k / 2] : BG)) begin
          n_fail++;
          $display("FAIL resync k=%0d got %h want %h", k, bus.pixel_o, (k < 8) ? ram[k / 2] : BG);
        end
        k++;
      end
    end
    n_checks++;
    if (k != 10) begin
      n_fail++;
      $display("FAIL resync_len got %0d de_o cycles want 10", k);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i] = 8'($urandom);
      if (ram[i] == BG) ram[i] = 8'h00;
    end
    bus.de_i = 1'b0; bus.hsync_i = 1'b0; bus.vsync_i = 1'b0;
    rst = 1'b1;
    test_reset();
    idle(2, 1'b0);
    test_line_addr();
    test_frame();
    test_latency();
    test_random();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
